// File: rtl/ivl_uvm_ovl_pkg.sv
// Shared types and constants for the ovl_increment stimulus generator.
// Holds the sequencer state encoding and counter widths.
package ivl_uvm_ovl_pkg;

   localparam int STEP_CNT_W = 8;
   localparam int HOLD_W     = 4;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_HOLD = 3'd2,
      S_STEP = 3'd3,
      S_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/ivl_uvm_ovl_hold_timer.sv
// Hold countdown for the stimulus generator.
// Ports: clock, reset (sync, active-low), i_load/i_count reload the
// counter, i_en decrements it, o_expire is high when it reaches zero.
module ivl_uvm_ovl_hold_timer
   import ivl_uvm_ovl_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              i_load,
   input  logic              i_en,
   input  logic [HOLD_W-1:0] i_count,
   output logic              o_expire
);

   logic [HOLD_W-1:0] r_cnt;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_count;
      end else if (i_en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/ivl_uvm_ovl_incr_stim_gen.sv
// Stimulus generator driving test_expr for an ovl_increment checker.
// Ports: clock, reset (sync, active-low), enable (freeze when low),
// start + init_value/num_steps/hold_cycles/err_inject_en/err_step
// (captured on accepted start); outputs test_expr, busy, done,
// fire_expected and wrap.
module ivl_uvm_ovl_incr_stim_gen
   import ivl_uvm_ovl_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned VALUE = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  start,
   input  logic [WIDTH-1:0]      init_value,
   input  logic [STEP_CNT_W-1:0] num_steps,
   input  logic [HOLD_W-1:0]     hold_cycles,
   input  logic                  err_inject_en,
   input  logic [STEP_CNT_W-1:0] err_step,
   output logic [WIDTH-1:0]      test_expr,
   output logic                  busy,
   output logic                  done,
   output logic                  fire_expected,
   output logic                  wrap
);

   localparam logic [WIDTH:0] VAL_EXT = (WIDTH+1)'(VALUE);

   state_t                r_state;
   logic [WIDTH-1:0]      r_test;
   logic [STEP_CNT_W-1:0] r_cnt;
   logic [STEP_CNT_W-1:0] r_num;
   logic [HOLD_W-1:0]     r_hold;
   logic                  r_err_en;
   logic [STEP_CNT_W-1:0] r_err_step;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_fire;
   logic                  r_wrap;

   logic                  w_expire;
   logic                  w_tmr_load;
   logic                  w_tmr_en;
   logic                  w_inj;
   logic [STEP_CNT_W:0]   w_cnt_p1;
   logic [WIDTH:0]        w_sum;

   // Extra bit so step 255 still compares correctly against err_step.
   assign w_cnt_p1 = {1'b0, r_cnt} + 1'b1;
   assign w_inj    = r_err_en && (w_cnt_p1 == {1'b0, r_err_step});

   // Unreduced sum; its top bit is the wrap indication.
   assign w_sum = {1'b0, r_test} + VAL_EXT + {{WIDTH{1'b0}}, w_inj};

   // Timer reloads on every entry into HOLD.
   assign w_tmr_load = enable &&
      (((r_state == S_LOAD) && (r_num != '0)) ||
       ((r_state == S_STEP) && (r_cnt < r_num)));
   assign w_tmr_en = enable && (r_state == S_HOLD);

   ivl_uvm_ovl_hold_timer u_hold (
      .clock    (clock),
      .reset    (reset),
      .i_load   (w_tmr_load),
      .i_en     (w_tmr_en),
      .i_count  (r_hold),
      .o_expire (w_expire)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_test     <= '0;
         r_cnt      <= '0;
         r_num      <= '0;
         r_hold     <= '0;
         r_err_en   <= 1'b0;
         r_err_step <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fire     <= 1'b0;
         r_wrap     <= 1'b0;
      end else if (enable) begin
         r_done <= 1'b0;
         r_fire <= 1'b0;
         r_wrap <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_num      <= num_steps;
                  r_hold     <= hold_cycles;
                  r_err_en   <= err_inject_en;
                  r_err_step <= err_step;
                  r_test     <= init_value;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (r_num != '0) begin
                  r_state <= S_HOLD;
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_HOLD: begin
               // The step value is committed as STEP is entered.
               if (w_expire) begin
                  r_test  <= w_sum[WIDTH-1:0];
                  r_wrap  <= w_sum[WIDTH];
                  r_fire  <= w_inj;
                  r_cnt   <= r_cnt + 1'b1;
                  r_state <= S_STEP;
               end
            end
            S_STEP: begin
               if (r_cnt < r_num) begin
                  r_state <= S_HOLD;
               end else begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Pulses are masked while frozen; they reappear once on resume.
   assign test_expr     = r_test;
   assign busy          = r_busy;
   assign done          = r_done & enable;
   assign fire_expected = r_fire & enable;
   assign wrap          = r_wrap & enable;

endmodule

// File: tb/tb_ivl_uvm_ovl_incr_stim_gen.sv
// Directed bench for the ovl_increment stimulus generator.
// Two instances: VALUE=1 and VALUE=2, both WIDTH=4, sharing inputs.
module tb_ivl_uvm_ovl_incr_stim_gen;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic       start;
   logic [3:0] init_value;
   logic [7:0] num_steps;
   logic [3:0] hold_cycles;
   logic       err_inject_en;
   logic [7:0] err_step;

   logic [3:0] te1, te2;
   logic       busy1, busy2, done1, done2;
   logic       fire1, fire2, wrap1, wrap2;

   always #5 clock = ~clock;

   ivl_uvm_ovl_incr_stim_gen #(.WIDTH(4), .VALUE(1)) dut_v1 (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .start         (start),
      .init_value    (init_value),
      .num_steps     (num_steps),
      .hold_cycles   (hold_cycles),
      .err_inject_en (err_inject_en),
      .err_step      (err_step),
      .test_expr     (te1),
      .busy          (busy1),
      .done          (done1),
      .fire_expected (fire1),
      .wrap          (wrap1)
   );

   ivl_uvm_ovl_incr_stim_gen #(.WIDTH(4), .VALUE(2)) dut_v2 (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .start         (start),
      .init_value    (init_value),
      .num_steps     (num_steps),
      .hold_cycles   (hold_cycles),
      .err_inject_en (err_inject_en),
      .err_step      (err_step),
      .test_expr     (te2),
      .busy          (busy2),
      .done          (done2),
      .fire_expected (fire2),
      .wrap          (wrap2)
   );

   // te/fire/wrap: index 0 is the LOAD cycle, leftmost in the literal.
   typedef struct packed {
      logic             v2;
      logic [3:0]       init;
      logic [7:0]       num;
      logic [3:0]       hold;
      logic             err_en;
      logic [7:0]       err_stp;
      logic             mid_start;
      int               len;
      logic [0:15][3:0] te;
      logic [0:15]      fire_m;
      logic [0:15]      wrap_m;
   } vec_t;

   vec_t vt [9];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      int edges;
      logic got;
      logic [3:0] a_te;
      logic a_busy, a_done, a_fire, a_wrap;

      //        v2    init   num    hold  en    estp   mid  len
      vt[0] = '{1'b1, 4'd0,  8'd3, 4'd0, 1'b0, 8'd0, 1'b0, 8,
                64'h0022446600000000, 16'h0000, 16'h0000};
      vt[1] = '{1'b0, 4'd14, 8'd3, 4'd0, 1'b0, 8'd0, 1'b0, 8,
                64'hEEFF001100000000, 16'h0000, 16'h0800};
      vt[2] = '{1'b0, 4'd0,  8'd3, 4'd0, 1'b1, 8'd2, 1'b0, 8,
                64'h0011334400000000, 16'h0800, 16'h0000};
      vt[3] = '{1'b0, 4'd3,  8'd2, 4'd2, 1'b0, 8'd0, 1'b1, 10,
                64'h3333444455000000, 16'h0000, 16'h0000};
      vt[4] = '{1'b0, 4'd9,  8'd0, 4'd0, 1'b0, 8'd0, 1'b0, 2,
                64'h9900000000000000, 16'h0000, 16'h0000};
      vt[5] = '{1'b0, 4'd0,  8'd3, 4'd0, 1'b1, 8'd5, 1'b0, 8,
                64'h0011223300000000, 16'h0000, 16'h0000};
      vt[6] = '{1'b0, 4'd7,  8'd2, 4'd0, 1'b1, 8'd0, 1'b0, 6,
                64'h7788990000000000, 16'h0000, 16'h0000};
      vt[7] = '{1'b0, 4'd14, 8'd1, 4'd0, 1'b1, 8'd1, 1'b0, 4,
                64'hEE00000000000000, 16'h2000, 16'h2000};
      vt[8] = '{1'b1, 4'd15, 8'd1, 4'd1, 1'b0, 8'd0, 1'b0, 5,
                64'hFFF1100000000000, 16'h0000, 16'h1000};

      reset = 1'b0;
      enable = 1'b1;
      start = 1'b0;
      init_value = 4'd0;
      num_steps = 8'd0;
      hold_cycles = 4'd0;
      err_inject_en = 1'b0;
      err_step = 8'd0;
      tick();
      tick();
      chk("rst.te1", 32'(te1), 0);
      chk("rst.te2", 32'(te2), 0);
      chk("rst.busy", 32'(busy1), 0);
      chk("rst.done", 32'(done1), 0);
      chk("rst.fire", 32'(fire1), 0);
      chk("rst.wrap", 32'(wrap1), 0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 9; i++) begin
         init_value = vt[i].init;
         num_steps = vt[i].num;
         hold_cycles = vt[i].hold;
         err_inject_en = vt[i].err_en;
         err_step = vt[i].err_stp;
         start = 1'b1;
         tick();
         start = 1'b0;
         for (int c = 0; c < vt[i].len; c++) begin
            a_te   = vt[i].v2 ? te2 : te1;
            a_busy = vt[i].v2 ? busy2 : busy1;
            a_done = vt[i].v2 ? done2 : done1;
            a_fire = vt[i].v2 ? fire2 : fire1;
            a_wrap = vt[i].v2 ? wrap2 : wrap1;
            chk($sformatf("v%0d.c%0d.te", i, c), 32'(a_te),
                32'(vt[i].te[c]));
            chk($sformatf("v%0d.c%0d.fire", i, c), 32'(a_fire),
                32'(vt[i].fire_m[c]));
            chk($sformatf("v%0d.c%0d.wrap", i, c), 32'(a_wrap),
                32'(vt[i].wrap_m[c]));
            chk($sformatf("v%0d.c%0d.busy", i, c), 32'(a_busy),
                32'(c != vt[i].len - 1));
            chk($sformatf("v%0d.c%0d.done", i, c), 32'(a_done),
                32'(c == vt[i].len - 1));
            if (vt[i].mid_start && c == 2) begin
               start = 1'b1;
               init_value = 4'hA;
            end else begin
               start = 1'b0;
               init_value = vt[i].init;
            end
            tick();
         end
         start = 1'b0;
         chk($sformatf("v%0d.idle.busy", i), 32'(busy1 | busy2), 0);
         chk($sformatf("v%0d.idle.done", i), 32'(done1 | done2), 0);
      end

      // Freeze for 5 cycles in HOLD; enabled latency must stay 8.
      init_value = 4'd2;
      num_steps = 8'd2;
      hold_cycles = 4'd1;
      err_inject_en = 1'b0;
      err_step = 8'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      chk("frz.load.te", 32'(te1), 2);
      tick();
      edges++;
      enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("frz.%0d.te", k), 32'(te1), 2);
         chk($sformatf("frz.%0d.busy", k), 32'(busy1), 1);
         chk($sformatf("frz.%0d.pulses", k),
             32'(done1 | fire1 | wrap1), 0);
      end
      enable = 1'b1;
      got = 1'b0;
      while (!got && edges < 40) begin
         tick();
         edges++;
         if (done1) got = 1'b1;
      end
      chk("frz.latency", 32'(edges), 8);
      chk("frz.final.te", 32'(te1), 4);
      tick();

      // Abort with reset after step 2, then restart from 5.
      init_value = 4'd0;
      num_steps = 8'd4;
      hold_cycles = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("abort.pre.te", 32'(te1), 2);
      reset = 1'b0;
      tick();
      chk("abort.rst.te", 32'(te1), 0);
      chk("abort.rst.busy", 32'(busy1), 0);
      chk("abort.rst.pulses", 32'(done1 | fire1 | wrap1), 0);
      tick();
      chk("abort.rst2.te", 32'(te1), 0);
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("abort.idle%0d.done", k), 32'(done1), 0);
      end
      init_value = 4'd5;
      num_steps = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      chk("restart.te", 32'(te1), 5);
      chk("restart.busy", 32'(busy1), 1);
      got = 1'b0;
      while (!got && edges < 20) begin
         tick();
         edges++;
         if (done1) got = 1'b1;
      end
      chk("restart.latency", 32'(edges), 4);
      chk("restart.final.te", 32'(te1), 6);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ivl_uvm_ovl_incr_stim_gen.md
IVL_UVM_OVL_INCR_STIM_GEN -- requirements
Module: ivl_uvm_ovl_incr_stim_gen

Interface
REQ-001 Parameter WIDTH, default 4: width of test_expr and init_value.
REQ-002 Parameter VALUE, default 1: legal increment per step, 1 to 2^WIDTH-1.
REQ-003 clock  input  1  single clock; all logic updates on posedge clock.
REQ-004 reset  input  1  synchronous, active-low reset; sampled only on posedge clock.
REQ-005 enable  input  1  high: sequence advances; low: all state frozen.
REQ-006 start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-007 init_value  input  WIDTH  first test_expr value of a sequence; captured on accepted start.
REQ-008 num_steps  input  8  number of increments; captured on accepted start.
REQ-009 hold_cycles  input  4  extra cycles test_expr stays stable between steps; captured on accepted start.
REQ-010 err_inject_en  input  1  enables one deliberate violation per sequence; captured on accepted start.
REQ-011 err_step  input  8  step index, 1-based, carrying the violation; captured on accepted start.
REQ-012 test_expr  output  WIDTH  driven stimulus for an ovl_increment checker.
REQ-013 busy  output  1  high in LOAD, HOLD and STEP.
REQ-014 done  output  1  one-cycle pulse on entry to DONE.
REQ-015 fire_expected  output  1  high for exactly the cycle test_expr shows an illegal change.
REQ-016 wrap  output  1  high for exactly the cycle test_expr wrapped modulo 2^WIDTH.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, HOLD, STEP and DONE.
REQ-018 IDLE->LOAD on start=1 with enable=1; inputs captured; start in any other state ignored.
REQ-019 In LOAD, test_expr SHALL take init_value; next state HOLD if num_steps>0, else DONE.
REQ-020 HOLD SHALL last hold_cycles+1 enabled cycles with test_expr unchanged, then go to STEP.
REQ-021 In STEP, test_expr SHALL update once; step count increments; next state HOLD if count<num_steps, else DONE.
REQ-022 Legal step: test_expr <= (test_expr+VALUE) mod 2^WIDTH.
REQ-023 Violation step (err_inject_en=1, count+1==err_step): test_expr <= (test_expr+VALUE+1) mod 2^WIDTH, fire_expected=1 that cycle.
REQ-024 err_step=0 or err_step>num_steps SHALL inject nothing.
REQ-025 wrap=1 when the unreduced sum is at least 2^WIDTH; wrap and fire_expected may be high together.
REQ-026 DONE SHALL pulse done for one cycle, hold test_expr, and return to IDLE.
REQ-027 enable=0 SHALL freeze state, counters and test_expr; done, fire_expected and wrap SHALL be 0 while frozen.
REQ-028 Latency: first step at cycle 2+hold_cycles after start; total start-to-done = 2+num_steps*(hold_cycles+2) enabled cycles.

Reset
REQ-029 reset=0 at a posedge SHALL force IDLE, test_expr=0, busy=0, done=0, fire_expected=0, wrap=0, and clear all counters and captured inputs.
REQ-030 Reset mid-sequence SHALL abort immediately, with no done pulse; a start after reset release begins a fresh sequence.

Structure
REQ-031 The state enum typedef SHALL live in the shared package ivl_uvm_ovl_pkg, along with localparam STEP_CNT_W=8.
REQ-032 The hold countdown SHALL be one sub-module, ivl_uvm_ovl_hold_timer (load, enable, count, expire); all other logic is in the top.

Verification
REQ-033 WIDTH=4, VALUE=2, init=0, num_steps=3, hold=0 -> test_expr 0,0,2,2,4,4,6; done pulses; fire_expected and wrap stay 0.
REQ-034 init=14, VALUE=1, num_steps=3 -> test_expr 14,15,0,1; wrap=1 only on the 15->0 cycle.
REQ-035 err_inject_en=1, err_step=2, VALUE=1, init=0, num_steps=3 -> test_expr 0,1,3,4; fire_expected=1 only on the 1->3 cycle.
REQ-036 enable=0 for 5 cycles mid-HOLD -> test_expr and state unchanged; sequence resumes and total enabled latency matches REQ-028.
REQ-037 reset=0 after step 2, then start again with init=5 -> outputs 0 during reset; no done from the aborted run; new sequence starts at 5.
REQ-038 start during busy, and num_steps=0 -> extra start ignored; num_steps=0 gives LOAD then DONE, done 2 cycles after start, test_expr=init_value.
